// File: rtl/arb_pkg.sv
// Shared constants and types for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HOLD_W  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Result of one round-robin search over a candidate vector.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/decoder_3_8.sv
// 3-to-8 one-hot decoder with enable; output is all zero when disabled.
module decoder_3_8 (
    input  logic [2:0] in_i,
    input  logic       en_i,
    output logic [7:0] dec_o
);

    always_comb begin
        dec_o = 8'h00;
        if (en_i) begin
            dec_o = 8'(8'h01 << in_i);
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with bounded grant hold under contention.
// All outputs derive from state registers only; req never reaches an output combinationally.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

    arb_state_e         st_q,    st_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;

    logic [NUM_REQ-1:0] own_mask_c;
    logic [NUM_REQ-1:0] others_c;
    logic [NUM_REQ-1:0] cand_c;
    pick_t              pick_c;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] cand,
                                      input logic [IDX_W-1:0]   start);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        pick_t                p;
        p   = '0;
        dbl = {cand, cand};
        rot = NUM_REQ'(dbl >> start);
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                p.found = 1'b1;
                p.idx   = IDX_W'(i);
            end
        end
        p.idx = p.idx + start;
        return p;
    endfunction

    // The owner is never its own candidate: on release its bit is already low,
    // on preemption it must be excluded.
    always_comb begin
        own_mask_c = NUM_REQ'(1) << owner_q;
        others_c   = req & ~own_mask_c;
        cand_c     = (st_q == ST_OWNED) ? others_c : req;
        pick_c     = rr_pick(cand_c, ptr_q);
    end

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (st_q)
            ST_IDLE: begin
                if (pick_c.found) begin
                    st_d    = ST_OWNED;
                    owner_d = pick_c.idx;
                    ptr_d   = pick_c.idx + IDX_W'(1);
                    hold_d  = '0;
                end
            end
            ST_OWNED: begin
                if (!req[owner_q] || ((|others_c) && (hold_q >= HOLD_LIM))) begin
                    if (pick_c.found) begin
                        owner_d = pick_c.idx;
                        ptr_d   = pick_c.idx + IDX_W'(1);
                        hold_d  = '0;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_valid = (st_q == ST_OWNED);
    assign gnt_idx   = owner_q;

    decoder_3_8 u_gnt_dec (
        .in_i  (owner_q),
        .en_i  (st_q == ST_OWNED),
        .dec_o (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed and random checks of rr_arbiter_8 against a behavioural arbitration model.
module tb_rr_arbiter_8;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int tests = 0;
    int fails = 0;

    int m_owner;
    int m_ptr;
    int m_hold;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rules: owner keeps the grant unless it releases or has held
    // MAX_HOLD cycles while someone else waits; then search from ptr upward.
    function automatic void model_step(input logic [7:0] r, input logic rn);
        logic [7:0] cand;
        int         found;
        if (!rn) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            return;
        end
        cand = r;
        if (m_owner >= 0) begin
            cand[m_owner] = 1'b0;
            if (r[m_owner] && (cand == 8'h00 || m_hold < int'(MAX_HOLD) - 1)) begin
                if (m_hold < 15) m_hold++;
                return;
            end
        end
        found = -1;
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (m_ptr + k) % 8;
            if (cand[j] && found < 0) found = j;
        end
        if (found >= 0) begin
            m_owner = found;
            m_ptr   = (found + 1) % 8;
            m_hold  = 0;
        end else begin
            m_owner = -1;
        end
    endfunction

    task automatic tick();
        logic [31:0] exp_gnt;
        @(posedge clk);
        model_step(req, rst_n);
        #1;
        exp_gnt = (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
        check("gnt", 32'(gnt), exp_gnt);
        check("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'h1 : 32'h0);
        if (m_owner >= 0) check("gnt_idx", 32'(gnt_idx), 32'(m_owner));
        check("onehot_consistent", 32'(($countones(gnt) <= 1) && ((gnt != 8'h00) == gnt_valid)), 32'h1);
    endtask

    task automatic drive(input logic [7:0] r, input int n);
        req = r;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic [7:0] r, input int n);
        rst_n = 1'b0;
        drive(r, n);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 8'h00;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        #1;

        // Reset with every request high, then first grant from ptr 0.
        do_reset(8'hFF, 2);
        check("reset_gnt", 32'(gnt), 32'h00);
        check("reset_valid", 32'(gnt_valid), 32'h0);

        // Full contention rotation: each requester gets MAX_HOLD cycles.
        req = 8'hFF;
        for (int i = 0; i < 36; i++) begin
            tick();
            check("rotation", 32'(gnt), 32'h1 << ((i / int'(MAX_HOLD)) % 8));
        end

        // Release handoff with no idle bubble.
        do_reset(8'h00, 1);
        drive(8'h24, 1);
        check("handoff_first", 32'(gnt), 32'h04);
        drive(8'h20, 1);
        check("handoff_next", 32'(gnt), 32'h20);
        drive(8'h00, 1);
        check("handoff_idle", 32'(gnt_valid), 32'h0);

        // Uncontended hold saturates without preemption, then yields at once.
        drive(8'h08, 40);
        check("uncontended_hold", 32'(gnt), 32'h08);
        drive(8'h0A, 1);
        check("late_preempt", 32'(gnt), 32'h02);
        drive(8'h0A, 4);

        // Wrap-around from requester 7 to 0 and back.
        do_reset(8'h00, 1);
        drive(8'h80, 1);
        drive(8'h81, 1);
        check("wrap_hold7", 32'(gnt), 32'h80);
        drive(8'h01, 1);
        check("wrap_to0", 32'(gnt), 32'h01);
        drive(8'h80, 1);
        check("wrap_back7", 32'(gnt), 32'h80);

        // Reset in the middle of a grant restarts the search at ptr 0.
        do_reset(8'h00, 1);
        drive(8'h10, 2);
        check("mid_grant", 32'(gnt), 32'h10);
        do_reset(8'h10, 1);
        check("mid_reset", 32'(gnt), 32'h00);
        drive(8'h30, 1);
        check("post_reset", 32'(gnt), 32'h10);

        // Random traffic with held request patterns and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) req = 8'($urandom & $urandom);
            rst_n = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
